// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port between NREQ producers.
// Grants are combinational (zero latency) and bursts are capped at MAXBURST while others wait.
module fifo_wr_arbiter #(
   parameter int NREQ     = 4,
   parameter int DW       = 8,
   parameter int MAXBURST = 4,
   localparam int OW      = $clog2(NREQ),
   localparam int BW      = (MAXBURST > 1) ? $clog2(MAXBURST) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               fifo_full,
   output logic [NREQ-1:0]    ack,
   output logic               fifo_wr_en,
   output logic [DW-1:0]      fifo_wr_data,
   output logic [OW-1:0]      owner,
   output logic [BW-1:0]      burst_cnt
);

   localparam logic [OW-1:0] OWNER_RST = OW'(NREQ-1);
   localparam logic [BW-1:0] BURST_MAX = BW'(MAXBURST-1);

   logic [OW-1:0]   owner_q, owner_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [NREQ-1:0] ack_d;
   logic [NREQ-1:0] owner_oh;
   logic            others;
   logic            cont;
   logic            found;
   logic [OW-1:0]   win;

   always_comb begin
      owner_oh = '0;
      owner_oh[owner_q] = 1'b1;
   end

   assign others = |(req & ~owner_oh);
   assign cont   = req[owner_q] && ((burst_q < BURST_MAX) || !others);

   // Search starts just after the owner and wraps, so the owner is checked last.
   always_comb begin
      found = 1'b0;
      win   = owner_q;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[(int'(owner_q) + k) % NREQ]) begin
            found = 1'b1;
            win   = OW'((int'(owner_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      ack_d   = '0;
      owner_d = owner_q;
      burst_d = burst_q;
      if (rst && !fifo_full) begin
         if (cont) begin
            ack_d[owner_q] = 1'b1;
            if (burst_q < BURST_MAX) burst_d = burst_q + 1'b1;
         end else if (found) begin
            ack_d[win] = 1'b1;
            owner_d    = win;
            burst_d    = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q <= OWNER_RST;
         burst_q <= BURST_MAX;
      end else begin
         owner_q <= owner_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      fifo_wr_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (ack_d[i]) fifo_wr_data = fifo_wr_data | req_data[i*DW +: DW];
   end

   assign ack        = ack_d;
   assign fifo_wr_en = |ack_d;
   assign owner      = owner_q;
   assign burst_cnt  = burst_q;

endmodule
